// File: rtl/tt_memop_seq_pkg.sv
// Shared types, sizes and helpers for the vector memop sequencer.
package tt_memop_seq_pkg;

   localparam int unsigned VLEN          = 256;
   localparam int unsigned VL_W          = $clog2(VLEN + 1);
   localparam int unsigned MAX_IDX_BEATS = 8;
   localparam int unsigned BEAT_W        = 8;
   localparam int unsigned BITS_W        = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      IDX,
      COUNT,
      WAIT,
      END
   } memop_seq_state_t;

   typedef struct packed {
      logic            masked;
      logic            indexed;
      logic [VL_W-1:0] vl;
      logic [1:0]      eew;
      logic [VLEN-1:0] mask;
   } memop_desc_t;

   // Number of VLEN-wide index beats holding vl elements of width 8<<eew.
   function automatic logic [BEAT_W-1:0] calc_idx_beats(input logic [VL_W-1:0] vl,
                                                        input logic [1:0]      eew);
      logic [BITS_W-1:0] bits;
      bits = BITS_W'(vl) << ({1'b0, eew} + 3'd3);
      return BEAT_W'((bits + BITS_W'(VLEN - 1)) >> $clog2(VLEN));
   endfunction

endpackage

// File: rtl/tt_memop_seq_desc_fifo.sv
// Small valid/ready descriptor queue; a pop frees a slot for a same-cycle push.
module tt_memop_seq_desc_fifo
   import tt_memop_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_push,
   input  memop_desc_t i_push_data,
   input  logic        i_pop,
   output logic        o_full,
   output logic        o_empty,
   output memop_desc_t o_head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   memop_desc_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_full  = (count == CNT_W'(DEPTH));
   assign o_empty = (count == '0);
   assign o_head  = mem[rd_ptr];
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/tt_memop_seq.sv
// Serialises vector memop descriptors into the mask/index FSM.
// Optional perf counters under TT_MEMOP_SEQ_PERF_EN.
module tt_memop_seq
   import tt_memop_seq_pkg::*;
#(
   parameter int unsigned DESC_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_desc_valid,
   output logic            o_desc_ready,
   input  logic            i_desc_masked,
   input  logic            i_desc_indexed,
   input  logic [VL_W-1:0] i_desc_vl,
   input  logic [1:0]      i_desc_eew,
   input  logic [VLEN-1:0] i_desc_mask,
   input  logic            i_idx_valid,
   output logic            o_idx_ready,
   input  logic [VLEN-1:0] i_idx_data,
   input  logic            i_mask_idx_valid,
   input  logic            i_lsu_done,
   output logic            o_is_masked_memop,
   output logic            o_is_indexed,
   output logic [VLEN-1:0] o_mask_data,
   output logic [VL_W-1:0] o_vl,
   output logic [1:0]      o_eew,
   output logic [VLEN-1:0] o_index_data,
   output logic            o_index_data_valid,
   output logic            o_last_index,
   output logic            o_memop_sync_start,
   output logic            o_memop_sync_end,
   output logic            o_busy,
   output logic            o_err
`ifdef TT_MEMOP_SEQ_PERF_EN
   ,
   output logic [31:0]     o_perf_memops,
   output logic [31:0]     o_perf_stall
`endif
);

   memop_seq_state_t  state;
   memop_desc_t       push_desc;
   memop_desc_t       head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic [BEAT_W-1:0] head_beats;
   logic              head_illegal;
   logic [VL_W-1:0]   head_exp;
   logic [BEAT_W-1:0] idx_beats;
   logic [BEAT_W-1:0] beat_cnt;
   logic [VL_W-1:0]   exp_items;
   logic [VL_W-1:0]   item_cnt;
   logic [VL_W-1:0]   cnt_next;
   logic              beat_last;
   logic              done_seen;
   logic              done_now;

   assign push_desc = '{masked: i_desc_masked, indexed: i_desc_indexed,
                        vl: i_desc_vl, eew: i_desc_eew, mask: i_desc_mask};

   tt_memop_seq_desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_push      (i_desc_valid),
      .i_push_data (push_desc),
      .i_pop       (pop),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_head      (head)
   );

   // Per-memop values derived from the queue head at pop time.
   assign head_beats   = calc_idx_beats(head.vl, head.eew);
   assign head_illegal = head.indexed &&
                         ((head_beats > BEAT_W'(MAX_IDX_BEATS)) || (head.vl == '0));
   assign head_exp     = head.indexed ? head.vl :
                         head.masked  ? VL_W'(({1'b0, head.vl} + (VL_W + 1)'(63)) >> 6) :
                                        '0;

   assign pop          = (state == IDLE) && !fifo_empty;
   assign o_desc_ready = !fifo_full || pop;
   assign o_idx_ready  = (state == IDX);
   assign o_busy       = (state != IDLE);
   assign cnt_next     = item_cnt + VL_W'(i_mask_idx_valid);
   assign beat_last    = (beat_cnt == idx_beats - BEAT_W'(1));
   assign done_now     = done_seen || i_lsu_done;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state              <= IDLE;
         o_is_masked_memop  <= 1'b0;
         o_is_indexed       <= 1'b0;
         o_mask_data        <= '0;
         o_vl               <= '0;
         o_eew              <= '0;
         o_index_data       <= '0;
         o_index_data_valid <= 1'b0;
         o_last_index       <= 1'b0;
         o_memop_sync_start <= 1'b0;
         o_memop_sync_end   <= 1'b0;
         o_err              <= 1'b0;
         idx_beats          <= '0;
         beat_cnt           <= '0;
         exp_items          <= '0;
         item_cnt           <= '0;
         done_seen          <= 1'b0;
      end else begin
         o_memop_sync_start <= 1'b0;
         o_memop_sync_end   <= 1'b0;
         o_err              <= 1'b0;
         o_index_data_valid <= 1'b0;
         o_last_index       <= 1'b0;
         // An early LSU completion is remembered until the memop closes.
         if ((state != IDLE) && (state != END) && i_lsu_done) done_seen <= 1'b1;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  if (head_illegal) begin
                     o_err <= 1'b1;
                  end else begin
                     o_is_masked_memop  <= head.masked;
                     o_is_indexed       <= head.indexed;
                     o_mask_data        <= head.mask;
                     o_vl               <= head.vl;
                     o_eew              <= head.eew;
                     idx_beats          <= head_beats;
                     exp_items          <= head_exp;
                     o_memop_sync_start <= 1'b1;
                     state              <= START;
                  end
               end
            end
            START: state <= o_is_indexed ? IDX : COUNT;
            IDX: begin
               item_cnt <= cnt_next;
               if (i_idx_valid) begin
                  o_index_data       <= i_idx_data;
                  o_index_data_valid <= 1'b1;
                  o_last_index       <= beat_last;
                  beat_cnt           <= beat_cnt + BEAT_W'(1);
                  if (beat_last) state <= COUNT;
               end
            end
            COUNT: begin
               item_cnt <= cnt_next;
               if (cnt_next >= exp_items) begin
                  if (done_now) begin
                     o_memop_sync_end <= 1'b1;
                     state            <= END;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (done_now) begin
                  o_memop_sync_end <= 1'b1;
                  state            <= END;
               end
            end
            END: begin
               done_seen <= 1'b0;
               item_cnt  <= '0;
               beat_cnt  <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TT_MEMOP_SEQ_PERF_EN
   // Saturating completion and stall counters.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_perf_memops <= '0;
         o_perf_stall  <= '0;
      end else begin
         if ((state == END) && (o_perf_memops != '1))
            o_perf_memops <= o_perf_memops + 32'd1;
         if ((((state == IDX) && !i_idx_valid) || (state == COUNT) || (state == WAIT)) &&
             (o_perf_stall != '1))
            o_perf_stall <= o_perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tt_memop_seq.sv
// Scoreboard bench for tt_memop_seq: descriptor, index-beat and sync sequencing.
module tb_tt_memop_seq;

   localparam int unsigned VLEN = 256;
   localparam int unsigned VL_W = 9;

   typedef struct {
      logic            err;
      logic            m;
      logic            ix;
      logic [VL_W-1:0] vl;
      logic [1:0]      eew;
      logic [VLEN-1:0] mask;
   } exp_desc_t;

   typedef struct {
      logic [VLEN-1:0] data;
      logic            last;
   } exp_beat_t;

   logic            i_clk = 1'b0;
   logic            i_reset_n;
   logic            i_desc_valid;
   logic            o_desc_ready;
   logic            i_desc_masked;
   logic            i_desc_indexed;
   logic [VL_W-1:0] i_desc_vl;
   logic [1:0]      i_desc_eew;
   logic [VLEN-1:0] i_desc_mask;
   logic            i_idx_valid;
   logic            o_idx_ready;
   logic [VLEN-1:0] i_idx_data;
   logic            i_mask_idx_valid;
   logic            i_lsu_done;
   logic            o_is_masked_memop;
   logic            o_is_indexed;
   logic [VLEN-1:0] o_mask_data;
   logic [VL_W-1:0] o_vl;
   logic [1:0]      o_eew;
   logic [VLEN-1:0] o_index_data;
   logic            o_index_data_valid;
   logic            o_last_index;
   logic            o_memop_sync_start;
   logic            o_memop_sync_end;
   logic            o_busy;
   logic            o_err;

   exp_desc_t sb[$];
   exp_beat_t beats[$];
   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;
   int end_cnt = 0;
   int err_cnt = 0;
   logic [VL_W-1:0] cur_vl = '0;

   always #5 i_clk = ~i_clk;

   tt_memop_seq dut (
      .i_clk              (i_clk),
      .i_reset_n          (i_reset_n),
      .i_desc_valid       (i_desc_valid),
      .o_desc_ready       (o_desc_ready),
      .i_desc_masked      (i_desc_masked),
      .i_desc_indexed     (i_desc_indexed),
      .i_desc_vl          (i_desc_vl),
      .i_desc_eew         (i_desc_eew),
      .i_desc_mask        (i_desc_mask),
      .i_idx_valid        (i_idx_valid),
      .o_idx_ready        (o_idx_ready),
      .i_idx_data         (i_idx_data),
      .i_mask_idx_valid   (i_mask_idx_valid),
      .i_lsu_done         (i_lsu_done),
      .o_is_masked_memop  (o_is_masked_memop),
      .o_is_indexed       (o_is_indexed),
      .o_mask_data        (o_mask_data),
      .o_vl               (o_vl),
      .o_eew              (o_eew),
      .o_index_data       (o_index_data),
      .o_index_data_valid (o_index_data_valid),
      .o_last_index       (o_last_index),
      .o_memop_sync_start (o_memop_sync_start),
      .o_memop_sync_end   (o_memop_sync_end),
      .o_busy             (o_busy),
      .o_err              (o_err)
   );

   task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [VLEN-1:0] rand256();
      logic [VLEN-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic tick();
      @(negedge i_clk);
   endtask

   // Output monitor: pops the scoreboards as starts, errors and beats appear.
   always @(negedge i_clk) begin
      exp_desc_t e;
      exp_beat_t b;
      if (i_reset_n) begin
         if (o_err) begin
            err_cnt++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("err_expected", 256'(e.err), 256'(1));
            end
         end
         if (o_memop_sync_start) begin
            start_cnt++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("start_not_illegal", 256'(e.err), 256'(0));
               chk("start_masked", 256'(o_is_masked_memop), 256'(e.m));
               chk("start_indexed", 256'(o_is_indexed), 256'(e.ix));
               chk("start_vl", 256'(o_vl), 256'(e.vl));
               chk("start_eew", 256'(o_eew), 256'(e.eew));
               chk("start_mask", o_mask_data, e.mask);
               cur_vl = e.vl;
            end
         end
         if (o_memop_sync_end) begin
            end_cnt++;
            chk("end_vl_held", 256'(o_vl), 256'(cur_vl));
         end
         if (o_index_data_valid && beats.size() > 0) begin
            b = beats.pop_front();
            chk("beat_data", o_index_data, b.data);
            chk("beat_last", 256'(o_last_index), 256'(b.last));
         end
      end
   end

   // Offers one descriptor (caller sits on a negedge) and records it on handshake.
   task automatic push_desc(input logic m, input logic ix, input logic [VL_W-1:0] vl,
                            input logic [1:0] eew, input logic ill);
      exp_desc_t e;
      int n = 0;
      i_desc_valid   = 1'b1;
      i_desc_masked  = m;
      i_desc_indexed = ix;
      i_desc_vl      = vl;
      i_desc_eew     = eew;
      i_desc_mask    = rand256();
      while (!o_desc_ready && n < 200) begin tick(); n++; end
      chk("push_ready", 256'(o_desc_ready), 256'(1));
      if (o_desc_ready) begin
         e.err = ill; e.m = m; e.ix = ix; e.vl = vl; e.eew = eew; e.mask = i_desc_mask;
         sb.push_back(e);
      end
      tick();
      i_desc_valid = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (!o_memop_sync_start && n < 300) begin tick(); n++; end
      chk(tag, 256'(o_memop_sync_start), 256'(1));
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (!o_memop_sync_end && n < 300) begin tick(); n++; end
      chk(tag, 256'(o_memop_sync_end), 256'(1));
   endtask

   task automatic items(input int n);
      for (int i = 0; i < n; i++) begin i_mask_idx_valid = 1'b1; tick(); end
      i_mask_idx_valid = 1'b0;
   endtask

   task automatic pulse_done();
      i_lsu_done = 1'b1;
      tick();
      i_lsu_done = 1'b0;
   endtask

   // Watches n cycles, starting now, for a premature sync_end.
   task automatic no_end(input int n, input string tag);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         if (o_memop_sync_end) seen++;
         tick();
      end
      chk(tag, 256'(seen), 256'(0));
   endtask

   // Offers beats (with gaps) past the expected count and snoops items while in IDX.
   task automatic run_beats(input int exp_beats, output int acc, output int idx_items);
      exp_beat_t b;
      int extra = 0;
      int cyc = 0;
      acc = 0;
      idx_items = 0;
      while (extra < 3 && cyc < 100) begin
         i_idx_valid      = (cyc % 3 != 1);
         i_idx_data       = rand256();
         i_mask_idx_valid = o_idx_ready;
         if (o_idx_ready) idx_items++;
         if (i_idx_valid && o_idx_ready) begin
            b.data = i_idx_data;
            b.last = (acc == exp_beats - 1);
            beats.push_back(b);
            acc++;
         end
         if (acc >= exp_beats && !o_idx_ready) extra++;
         tick();
         cyc++;
      end
      i_idx_valid      = 1'b0;
      i_mask_idx_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int it;
      int seen;
      i_reset_n = 1'b0;
      i_desc_valid = 1'b0; i_desc_masked = 1'b0; i_desc_indexed = 1'b0;
      i_desc_vl = '0; i_desc_eew = '0; i_desc_mask = '0;
      i_idx_valid = 1'b0; i_idx_data = '0; i_mask_idx_valid = 1'b0; i_lsu_done = 1'b0;
      tick();
      chk("rst_desc_ready", 256'(o_desc_ready), 256'(1));
      chk("rst_busy", 256'(o_busy), 256'(0));
      chk("rst_start", 256'(o_memop_sync_start), 256'(0));
      chk("rst_idx_ready", 256'(o_idx_ready), 256'(0));
      i_reset_n = 1'b1;
      tick(); tick();

      // Masked strided, vl=130: three items, done arrives before the last one.
      push_desc(1'b1, 1'b0, 9'd130, 2'd0, 1'b0);
      wait_start("t1_start");
      tick();
      items(2);
      pulse_done();
      no_end(3, "t1_no_end_before_items");
      items(1);
      wait_end("t1_end");
      tick();
      chk("t1_idle", 256'(o_busy), 256'(0));

      // Indexed, vl=64, eew=16b: four beats, 64 items.
      push_desc(1'b0, 1'b1, 9'd64, 2'd1, 1'b0);
      wait_start("t2_start");
      run_beats(4, acc, it);
      chk("t2_beats", 256'(acc), 256'(4));
      items(64 - it - 1);
      pulse_done();
      no_end(3, "t2_no_end_before_items");
      items(1);
      wait_end("t2_end");
      tick();

      // Unmasked, vl=32: done given during START is honoured.
      push_desc(1'b0, 1'b0, 9'd32, 2'd2, 1'b0);
      wait_start("t3_start");
      pulse_done();
      wait_end("t3_end");
      tick();
      chk("t3_idle", 256'(o_busy), 256'(0));

      // Two illegal descriptors, then the 8-beat boundary case.
      push_desc(1'b0, 1'b1, 9'd256, 2'd3, 1'b1);
      push_desc(1'b1, 1'b1, 9'd0, 2'd0, 1'b1);
      push_desc(1'b1, 1'b1, 9'd32, 2'd3, 1'b0);
      wait_start("t4_start");
      run_beats(8, acc, it);
      chk("t4_beats", 256'(acc), 256'(8));
      items(32 - it);
      pulse_done();
      wait_end("t4_end");
      tick();
      chk("t4_err_count", 256'(err_cnt), 256'(2));

      // Queue full while busy, then push concurrent with pop.
      push_desc(1'b0, 1'b0, 9'd16, 2'd0, 1'b0);
      wait_start("t5_start_a");
      push_desc(1'b1, 1'b0, 9'd64, 2'd0, 1'b0);
      push_desc(1'b0, 1'b0, 9'd1, 2'd1, 1'b0);
      chk("t5_full_ready", 256'(o_desc_ready), 256'(0));
      i_lsu_done = 1'b1;
      push_desc(1'b1, 1'b0, 9'd128, 2'd2, 1'b0);
      i_lsu_done = 1'b0;
      chk("t5_full_again", 256'(o_desc_ready), 256'(0));
      wait_start("t5_start_b");
      tick();
      items(1);
      pulse_done();
      wait_end("t5_end_b");
      wait_start("t5_start_c");
      pulse_done();
      wait_end("t5_end_c");
      wait_start("t5_start_d");
      tick();
      items(2);
      pulse_done();
      wait_end("t5_end_d");
      tick();
      chk("t5_idle", 256'(o_busy), 256'(0));

      // Reset in IDX after two beats; a queued descriptor must be discarded.
      push_desc(1'b0, 1'b1, 9'd64, 2'd1, 1'b0);
      push_desc(1'b0, 1'b0, 9'd4, 2'd0, 1'b0);
      wait_start("t6_start");
      acc = 0;
      for (int c = 0; c < 20 && acc < 2; c++) begin
         exp_beat_t b;
         i_idx_valid = 1'b1;
         i_idx_data  = rand256();
         if (o_idx_ready) begin
            b.data = i_idx_data; b.last = 1'b0;
            beats.push_back(b);
            acc++;
         end
         tick();
      end
      i_idx_valid = 1'b0;
      chk("t6_two_beats", 256'(acc), 256'(2));
      chk("t6_busy_before", 256'(o_busy), 256'(1));
      i_reset_n = 1'b0;
      #1;
      chk("t6_rst_busy", 256'(o_busy), 256'(0));
      chk("t6_rst_indexed", 256'(o_is_indexed), 256'(0));
      chk("t6_rst_vl", 256'(o_vl), 256'(0));
      chk("t6_rst_mask", o_mask_data, '0);
      chk("t6_rst_index_data", o_index_data, '0);
      chk("t6_rst_index_valid", 256'(o_index_data_valid), 256'(0));
      chk("t6_rst_idx_ready", 256'(o_idx_ready), 256'(0));
      chk("t6_rst_desc_ready", 256'(o_desc_ready), 256'(1));
      sb.delete();
      beats.delete();
      tick(); tick();
      i_reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (o_memop_sync_start || o_memop_sync_end) seen++;
      end
      chk("t6_queue_empty", 256'(seen), 256'(0));
      chk("t6_idle_after_rst", 256'(o_busy), 256'(0));
      push_desc(1'b1, 1'b0, 9'd64, 2'd0, 1'b0);
      wait_start("t6_fresh_start");
      tick();
      items(1);
      pulse_done();
      wait_end("t6_fresh_end");
      tick(); tick();

      chk("final_starts", 256'(start_cnt), 256'(10));
      chk("final_ends", 256'(end_cnt), 256'(9));
      chk("final_errs", 256'(err_cnt), 256'(2));
      chk("final_sb_empty", 256'(sb.size()), 256'(0));
      chk("final_beats_empty", 256'(beats.size()), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
